// File: rtl/gate_exercise_ctrl.sv
// Built-in exerciser for a 2-input gate: sweeps {A,B} through 00..11, lets each
// vector settle, then checks Y against a truth table and reports the results.
module gate_exercise_ctrl #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] TRUTH       = 4'b1001
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] FAIL_MASK,
    output logic [2:0] ERR_COUNT
);

    typedef enum logic [1:0] {IDLE, HOLD, CHECK, FINISH} state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] err_q, err_d;
    logic [3:0] truth_tbl;
    logic       mismatch;

    assign truth_tbl = TRUTH;
    assign mismatch  = (Y != truth_tbl[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = HOLD;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    mask_d  = 4'd0;
                    err_d   = 3'd0;
                end
            end
            HOLD: begin
                if (ABORT) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // Abort wins over the comparison: the partial results stay as they were.
                if (ABORT) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        mask_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        state_d = HOLD;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = 8'd0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 4'd0;
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    assign A         = idx_q[1];
    assign B         = idx_q[0];
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL_MASK = mask_q;
    assign ERR_COUNT = err_q;

endmodule
